ifetch_buffer: RTL and testbench

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

---
 rtl/ifetch_buffer.sv | 157 +++++++++++++++
 tb/tb_ifetch_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: fetches sequential words from imem and buffers them for decode.
// Latency: a word fetched in cycle N is at the head in cycle N+1; redirect/reset take effect next cycle.
// Backpressure: instr_ready low stalls decode; fetch stops (imem_addr frozen) once DEPTH entries are held.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   imem_addr / imem_ready / imem_rdata
//                              word address from the PC, wait-state qualifier, read data
//   redirect / redirect_pc     taken branch/jump: flush queue and restart fetch at redirect_pc
//   instr_valid / instr / pcplus4 / instr_ready
//                              head of queue to decode, with decode acceptance
//   count                      number of queued entries (0..DEPTH)
module ifetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IADDR_W  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [IADDR_W-1:0]       imem_addr,
  input  logic                     imem_ready,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              pcplus4,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } entry_t;

  // Architectural state
  logic [31:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  entry_t           head_q;

  // Queue storage; only the registered head copy needs a reset value
  entry_t           buf_q [DEPTH];

  // Next-state helpers
  logic             full;
  logic             push;
  logic             pop;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_pc_aligned;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  entry_t           push_entry;
  entry_t           head_nxt;

  // The two low bits of a redirect target carry no meaning for word fetch
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // Fetch side
  // ---------------------------------------------------------------------------
  assign imem_addr           = pc[IADDR_W+1:2];
  assign pc_plus4            = pc + 32'd4;  // wraps modulo 2^32
  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign push_entry          = '{instr: imem_rdata, pcplus4: pc_plus4};

  // ---------------------------------------------------------------------------
  // Handshakes. Redirect suppresses both sides in its cycle. A full queue still
  // accepts a fetch when the head leaves in the same cycle, so steady-state
  // throughput is one instruction per cycle.
  // ---------------------------------------------------------------------------
  assign full  = (count_q == CNT_W'(DEPTH));
  assign pop   = instr_valid & instr_ready & ~redirect;
  assign push  = imem_ready & ~redirect & (~full | pop);

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the natural
  // binary overflow is exactly the modulo-DEPTH wrap.
  assign rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;

  always_comb begin
    count_nxt = count_q;
    case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered head. The head is precomputed for the next cycle so decode sees
  // a flop output rather than a path from imem_rdata. If the new head slot is
  // the one being written this cycle, its contents come from the push data
  // (storage has not been written yet). When the queue becomes empty the head
  // keeps its previous contents.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_nxt = head_q;
    if (!redirect && (count_nxt != '0)) begin
      if (push && (rd_ptr_nxt == wr_ptr)) begin
        head_nxt = push_entry;
      end else begin
        head_nxt = buf_q[rd_ptr_nxt];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state. Reset beats redirect; redirect beats push/pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else if (redirect) begin
      pc      <= redirect_pc_aligned;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= head_q;
    end else begin
      if (push) begin
        pc <= pc_plus4;
      end
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      count_q <= count_nxt;
      head_q  <= head_nxt;
    end
  end

  // Storage write; no reset needed since count gates every read of it
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_q[wr_ptr] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count       = count_q;
  assign instr_valid = (count_q != '0);
  assign instr       = head_q.instr;
  assign pcplus4     = head_q.pcplus4;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Testbench for ifetch_buffer: directed phases plus a randomized run.
// A reference model of queue occupancy and fetch address pushes expected
// entries; a negedge monitor pops and compares as decode accepts them.
module tb_ifetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          IADDR_W  = 6;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic [IADDR_W-1:0]  imem_addr;
  logic                imem_ready;
  logic [31:0]         imem_rdata;
  logic                redirect;
  logic [31:0]         redirect_pc;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [31:0]         pcplus4;
  logic                instr_ready;
  logic [CW-1:0]       count;

  logic [31:0] mem [1<<IADDR_W];
  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IADDR_W(IADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pcplus4    (pcplus4),
    .instr_ready(instr_ready),
    .count      (count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  int          m_cnt     = 0;
  logic [31:0] m_pc      = 32'h0;
  int          rst_epoch = 0;
  int          seen_epoch = 0;
  exp_t        held      = '0;
  bit          mon_en    = 1'b0;
  int          n_cmp     = 0;
  int          n_err     = 0;

  // Reference model: occupancy and fetch address follow the queue rules;
  // every fetch pushes its expected {word, address+4} onto the scoreboard.
  always @(posedge clk) begin
    bit m_pop;
    bit m_push;
    if (reset) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc  = RESET_PC;
      rst_epoch++;
    end else if (redirect) begin
      exp_q.delete();
      m_cnt = 0;
      m_pc  = {redirect_pc[31:2], 2'b00};
    end else begin
      m_pop  = (m_cnt != 0) && instr_ready;
      m_push = imem_ready && ((m_cnt < DEPTH) || m_pop);
      if (m_push) begin
        exp_q.push_back({mem[m_pc[IADDR_W+1:2]], m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
      m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs on the falling edge and retires the head
  // from the scoreboard when decode accepts it.
  always @(negedge clk) begin
    if (mon_en) begin
      if (seen_epoch != rst_epoch) begin
        seen_epoch = rst_epoch;
        held = '0;
      end
      chk("count", 32'(count), 32'(m_cnt));
      chk("instr_valid", 32'(instr_valid), 32'(m_cnt != 0));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[IADDR_W+1:2]));
      if (m_cnt > DEPTH || m_cnt < 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL occupancy_range: got %0d expected 0..%0d", m_cnt, DEPTH);
      end
      if (m_cnt != 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_empty: got empty queue expected an entry at %0t", $time);
        end else begin
          held = exp_q[0];
        end
      end
      chk("instr", instr, held.instr);
      chk("pcplus4", pcplus4, held.pc4);
      if ((m_cnt != 0) && instr_ready && !redirect && !reset && (exp_q.size() != 0)) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input bit rs, input bit mr, input bit ir, input bit rd, input logic [31:0] rpc);
    reset       = rs;
    imem_ready  = mr;
    instr_ready = ir;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    reset       = 1'b1;
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(1, 0, 0, 0, 32'h0);

    // Streaming
    repeat (20) cyc(0, 1, 1, 0, 32'h0);

    // Fill and stall, then drain with fetch continuing
    repeat (8) cyc(0, 1, 0, 0, 32'h0);
    repeat (8) cyc(0, 1, 1, 0, 32'h0);

    // Wait states
    for (int i = 0; i < 12; i++) cyc(0, (i % 2) == 0, 1, 0, 32'h0);

    // Redirect with a full queue to an unaligned target
    repeat (6) cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 1, 32'h0000_0043);
    repeat (6) cyc(0, 1, 1, 0, 32'h0);

    // Back-to-back redirects: last target wins
    cyc(0, 1, 1, 1, 32'h0000_0100);
    cyc(0, 1, 1, 1, 32'h0000_0204);
    repeat (6) cyc(0, 1, 1, 0, 32'h0);

    // Address wrap at the top of the 32-bit space
    cyc(0, 1, 1, 1, 32'hFFFF_FFF4);
    repeat (8) cyc(0, 1, 1, 0, 32'h0);

    // Randomized run with gated readiness, rare redirects and resets
    repeat (600) cyc($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, $urandom);

    // Reset and redirect together with a partially full queue
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(1, 1, 1, 1, 32'h0000_0080);
    repeat (8) cyc(0, 1, 1, 0, 32'h0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
